// File: rtl/cpu_test_monitor_pkg.sv
// Shared types for the CPU test monitor: controller states and end_cause codes.
package cpu_test_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] END_EXHAUST = 2'd0;
  localparam logic [1:0] END_HALT    = 2'd1;
  localparam logic [1:0] END_TIMEOUT = 2'd2;
  localparam logic [1:0] END_FAIL    = 2'd3;

endpackage

// File: rtl/cpu_test_monitor_if.sv
// Monitor bundle: table loader, run control, observed CPU signals and result outputs.
interface cpu_test_monitor_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_TEST  = 58,
  parameter int TID_W     = $clog2(NUM_TEST),
  parameter int CYC_W     = 16
);
  logic                 load_en;
  logic [TID_W-1:0]     load_addr;
  logic [WORD_SIZE-1:0] load_inst;
  logic [WORD_SIZE-1:0] load_ans;
  logic                 start;
  logic [WORD_SIZE-1:0] num_inst;
  logic [WORD_SIZE-1:0] output_port;
  logic                 is_halted;
  logic                 busy;
  logic                 done;
  logic                 all_pass;
  logic [1:0]           end_cause;
  logic [TID_W:0]       pass_count;
  logic [TID_W:0]       fail_count;
  logic [TID_W:0]       skip_count;
  logic                 fail_valid;
  logic [TID_W-1:0]     fail_id;
  logic [WORD_SIZE-1:0] fail_got;
  logic [WORD_SIZE-1:0] fail_exp;
  logic [CYC_W-1:0]     cycle_count;

  modport master (
    output load_en, load_addr, load_inst, load_ans, start,
           num_inst, output_port, is_halted,
    input  busy, done, all_pass, end_cause, pass_count, fail_count, skip_count,
           fail_valid, fail_id, fail_got, fail_exp, cycle_count
  );

  modport slave (
    input  load_en, load_addr, load_inst, load_ans, start,
           num_inst, output_port, is_halted,
    output busy, done, all_pass, end_cause, pass_count, fail_count, skip_count,
           fail_valid, fail_id, fail_got, fail_exp, cycle_count
  );
endinterface

// File: rtl/cpu_test_table.sv
// Expected-result table: one synchronous write port, one asynchronous read port.
// Deliberately unreset so a loaded table survives reset across CPU reruns.
module cpu_test_table #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_TEST  = 58,
  parameter int TID_W     = $clog2(NUM_TEST)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [TID_W-1:0]     waddr,
  input  logic [WORD_SIZE-1:0] winst,
  input  logic [WORD_SIZE-1:0] wans,
  input  logic [TID_W-1:0]     raddr,
  output logic [WORD_SIZE-1:0] rinst,
  output logic [WORD_SIZE-1:0] rans
);
  logic [2*WORD_SIZE-1:0] mem [NUM_TEST];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {winst, wans};
  end

  assign {rinst, rans} = mem[raddr];
endmodule

// File: rtl/cpu_test_monitor.sv
// Self-checking CPU monitor: compares output_port against a loaded table as num_inst advances.
// Optional: define CPU_TEST_MONITOR_STOP_ON_FAIL_EN to end the run at the first mismatch.
module cpu_test_monitor
  import cpu_test_monitor_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 58,
  parameter int TID_W      = $clog2(NUM_TEST),
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 30000
) (
  input logic               clk,
  input logic               reset_n,
  cpu_test_monitor_if.slave mon
);
  localparam logic [TID_W-1:0] LAST_IDX   = TID_W'(NUM_TEST - 1);
  localparam logic [TID_W:0]   NUM_W      = (TID_W + 1)'(NUM_TEST);
  localparam logic [CYC_W-1:0] LAST_CYCLE = CYC_W'(MAX_CYCLES - 1);

  state_t               state, state_nx;
  logic [TID_W-1:0]     idx;
  logic [WORD_SIZE-1:0] exp_inst, exp_ans;
  logic                 table_we;
  logic                 hit, past, mismatch, last, stop_fail, term;
  logic [1:0]           cause;

  assign table_we = (state == IDLE) && mon.load_en && ({1'b0, mon.load_addr} < NUM_W);

  cpu_test_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .TID_W     (TID_W)
  ) u_table (
    .clk   (clk),
    .we    (table_we),
    .waddr (mon.load_addr),
    .winst (mon.load_inst),
    .wans  (mon.load_ans),
    .raddr (idx),
    .rinst (exp_inst),
    .rans  (exp_ans)
  );

  // Compare/skip decision and the prioritised termination reason for this cycle.
  always_comb begin
    hit       = (state == RUN) && (mon.num_inst == exp_inst);
    past      = (state == RUN) && (mon.num_inst > exp_inst);
    mismatch  = hit && (mon.output_port != exp_ans);
    last      = (hit || past) && (idx == LAST_IDX);
`ifdef CPU_TEST_MONITOR_STOP_ON_FAIL_EN
    stop_fail = mismatch;
`else
    stop_fail = 1'b0;
`endif
    term  = 1'b0;
    cause = END_EXHAUST;
    if (state == RUN) begin
      if (stop_fail) begin
        term  = 1'b1;
        cause = END_FAIL;
      end else if (last) begin
        term  = 1'b1;
        cause = END_EXHAUST;
      end else if (mon.is_halted) begin
        term  = 1'b1;
        cause = END_HALT;
      end else if (mon.cycle_count == LAST_CYCLE) begin
        term  = 1'b1;
        cause = END_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mon.start) state_nx = RUN;
      RUN:     if (term)      state_nx = DONE;
      DONE:    if (mon.start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx             <= '0;
      mon.busy        <= 1'b0;
      mon.done        <= 1'b0;
      mon.all_pass    <= 1'b0;
      mon.end_cause   <= '0;
      mon.pass_count  <= '0;
      mon.fail_count  <= '0;
      mon.skip_count  <= '0;
      mon.fail_valid  <= 1'b0;
      mon.fail_id     <= '0;
      mon.fail_got    <= '0;
      mon.fail_exp    <= '0;
      mon.cycle_count <= '0;
    end else begin
      mon.busy <= (state_nx == RUN);
      mon.done <= (state_nx == DONE);
      if (state == DONE && mon.start) begin
        idx             <= '0;
        mon.all_pass    <= 1'b0;
        mon.end_cause   <= '0;
        mon.pass_count  <= '0;
        mon.fail_count  <= '0;
        mon.skip_count  <= '0;
        mon.fail_valid  <= 1'b0;
        mon.fail_id     <= '0;
        mon.fail_got    <= '0;
        mon.fail_exp    <= '0;
        mon.cycle_count <= '0;
      end else if (state == RUN) begin
        if ((hit || past) && !last) idx <= idx + 1'b1;
        if (hit && !mismatch) mon.pass_count <= mon.pass_count + 1'b1;
        if (past) mon.skip_count <= mon.skip_count + 1'b1;
        if (mismatch) begin
          mon.fail_count <= mon.fail_count + 1'b1;
          if (!mon.fail_valid) begin
            mon.fail_valid <= 1'b1;
            mon.fail_id    <= idx;
            mon.fail_got   <= mon.output_port;
            mon.fail_exp   <= exp_ans;
          end
        end
        // The terminating cycle leaves cycle_count frozen at its sampled value.
        if (term) begin
          mon.end_cause <= cause;
          mon.all_pass  <= (mon.pass_count + (TID_W + 1)'(hit && !mismatch)) == NUM_W;
        end else if (mon.cycle_count != '1) begin
          mon.cycle_count <= mon.cycle_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/cpu_test_monitor.md
# cpu_test_monitor

Synthesizable self-checking monitor for the 16-bit pipelined CPU, sitting beside `cpu` and observing `num_inst`, `output_port` and `is_halted`. It holds a loadable table of (expected instruction count, expected WWD answer) pairs and compares `output_port` whenever `num_inst` reaches the current entry. It counts passes, captures the first failure, and terminates on table exhaustion, CPU halt or cycle timeout. This lets the same checks run on FPGA or in an emulator, with width, depth and timeout as parameters.

## Interface
- `WORD_SIZE`, 16, width of `num_inst`, `output_port` and the answer fields.
- `NUM_TEST`, 58, number of table entries; must be ≥ 2.
- `TID_W`, `$clog2(NUM_TEST)`, width of the test index.
- `CYC_W`, 16, width of the cycle counter.
- `MAX_CYCLES`, 30000, timeout in clk cycles counted in RUN; must be < 2^CYC_W.
- `clk`  in  1  clock; all logic samples on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `load_en`  in  1  writes one table entry; accepted only in IDLE.
- `load_addr`  in  TID_W  entry index; writes with `load_addr ≥ NUM_TEST` are ignored.
- `load_inst`  in  WORD_SIZE  expected `num_inst` value for the entry.
- `load_ans`  in  WORD_SIZE  expected `output_port` value for the entry.
- `start`  in  1  one-cycle pulse; moves IDLE to RUN.
- `num_inst`  in  WORD_SIZE  CPU retired-instruction count.
- `output_port`  in  WORD_SIZE  CPU WWD output.
- `is_halted`  in  1  CPU halt flag.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE.
- `all_pass`  out  1  `done` and `pass_count == NUM_TEST`.
- `end_cause`  out  2  reason for termination: 0 table exhausted, 1 halt, 2 timeout, 3 fail stop.
- `pass_count`  out  TID_W+1  number of entries that matched.
- `fail_count`  out  TID_W+1  number of entries that mismatched.
- `skip_count`  out  TID_W+1  number of entries skipped (no result).
- `fail_valid`  out  1  a failure has been captured.
- `fail_id`  out  TID_W  index of the first failing entry.
- `fail_got`  out  WORD_SIZE  `output_port` value at the first failure.
- `fail_exp`  out  WORD_SIZE  expected answer at the first failure.
- `cycle_count`  out  CYC_W  cycles spent in RUN; frozen in DONE.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE on a terminating event.
  - DONE → IDLE on `start`, which also clears counters and fail capture; the table is kept.
- Table entries must be sorted by strictly increasing `exp_inst`; this is the loader's responsibility and is not checked.
- In RUN, each cycle, with `idx` pointing at the current entry:
  - `num_inst == exp_inst[idx]`: compare. On a match, increment `pass_count`. On a mismatch, increment `fail_count` and, if `fail_valid` is low, capture `fail_id`, `fail_got` and `fail_exp`. Advance `idx` in both cases.
  - `num_inst > exp_inst[idx]` (unsigned), meaning the count stepped past the entry: increment `skip_count` and advance `idx`. No compare is made.
  - Otherwise: no action.
- Only one entry is evaluated per cycle. Each entry is judged on the first cycle it matches; later stall cycles at the same `num_inst` are not re-checked.
- Termination is evaluated after the same-cycle compare, with this priority:
  1. fail stop (3);
  2. last entry consumed (0);
  3. `is_halted` (1);
  4. `cycle_count == MAX_CYCLES-1` (2).
- A `load_en` outside IDLE is dropped. `start` in RUN is ignored.

## Timing
- Every output is registered. Counters and the fail capture reflect a compare in the cycle after it is sampled.
- `done` and `end_cause` become valid one cycle after the terminating sample. `busy` falls on the same edge that `done` rises.
- Table write latency is 1 cycle. An entry written at edge N can be used by a `start` sampled at edge N+1.
- Reset forces state IDLE. All outputs reset to 0, `idx` to 0 and `cycle_count` to 0.
- The table is not reset; it keeps its contents across reset so the CPU can be rerun. After power-up it is undefined until loaded.
- A reset during RUN aborts the run with no `done` pulse.
- `cycle_count` increments once per RUN cycle and saturates; it never wraps.

## Configuration
- `CPU_TEST_MONITOR_STOP_ON_FAIL_EN`
- Defined: the first mismatch terminates the run with `end_cause` = 3. `fail_count` is at most 1.
- Undefined: mismatches are counted and the first one is captured, but the run continues; `end_cause` 3 never occurs.

## Structure
- Package `cpu_test_monitor_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - the `end_cause` constants `END_EXHAUST`, `END_HALT`, `END_TIMEOUT`, `END_FAIL`.
- Sub-module `cpu_test_table`: a NUM_TEST × (2·WORD_SIZE) register file with one synchronous write port and one asynchronous read port indexed by `idx`.

## Test plan
- Load 3 entries (3/0x0000, 5/0x0001, 7/0xFFFE), start, drive `num_inst` 0..7 with matching `output_port` → `done`, `end_cause` = 0, `pass_count` = 3, `all_pass` = 1.
- Same table, but `output_port` = 0x0002 at `num_inst` = 5 → `fail_id` = 1, `fail_got` = 0x0002, `fail_exp` = 0x0001. With the macro defined: `end_cause` = 3, `pass_count` = 1. Without it: `end_cause` = 0, `pass_count` = 2, `fail_count` = 1.
- `num_inst` held at 5 for 4 cycles while `output_port` changes after the first cycle → only the first cycle is judged, and `pass_count` increments exactly once.
- `num_inst` jumps from 4 to 6 → entry 1 is skipped: `skip_count` = 1 and `all_pass` = 0.
- `is_halted` asserted at `num_inst` = 5 in the same cycle as a matching compare → entry 1 passes, `end_cause` = 1, `pass_count` = 2.
- `MAX_CYCLES` = 20 with `num_inst` stuck at 0 → `done` after 20 RUN cycles, `end_cause` = 2, `cycle_count` = 19. Asserting reset mid-run → state IDLE and all outputs 0, while a subsequent `start` still uses the retained table.
